// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg: shared defaults, state encoding and occupancy type for the
// elastic pipeline stage.  Revision: 1.0
// ============================================================================
package pipe_pkg;

  localparam logic [31:0] PIPE_PC_RST = 32'h0000_3008;
  localparam logic [31:0] PIPE_NOP    = 32'h0000_0000;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  typedef logic [1:0] pipe_occ_t;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// pipe_slot: one instr/pc8/data register slot with load and clear-to-bubble.
// Revision: 1.0
// ============================================================================
module pipe_slot #(
  parameter int          DATA_W       = 64,
  parameter logic [31:0] PC_RST       = 32'h0000_3008,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic              bubblePc,
  input  logic [31:0]       dInstr,
  input  logic [31:0]       dPc8,
  input  logic [DATA_W-1:0] dData,
  output logic [31:0]       qInstr,
  output logic [31:0]       qPc8,
  output logic [DATA_W-1:0] qData
);

  logic [31:0]       r_instr;
  logic [31:0]       r_pc8;
  logic [DATA_W-1:0] r_data;

  // Bubbling keeps pc8 unless bubblePc asks for the squashed slot's PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= BUBBLE_INSTR;
      r_pc8   <= PC_RST;
      r_data  <= '0;
    end else if (bubble) begin
      r_instr <= BUBBLE_INSTR;
      r_data  <= '0;
      if (bubblePc) r_pc8 <= dPc8;
    end else if (load) begin
      r_instr <= dInstr;
      r_pc8   <= dPc8;
      r_data  <= dData;
    end
  end

  assign qInstr = r_instr;
  assign qPc8   = r_pc8;
  assign qData  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic: valid/ready pipeline register with flush-to-bubble.
// Define PIPE_SKID_EN for a two-entry skid build with registered in_ready.
// Revision: 1.0
// ============================================================================
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int          DATA_W       = 64,
  parameter logic [31:0] PC_RST       = PIPE_PC_RST,
  parameter logic [31:0] BUBBLE_INSTR = PIPE_NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc8,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc8,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       r_state;
  pipe_state_e       w_nextState;
  logic              r_outValid;
  logic              w_inReady;
  logic              w_inFire;
  logic              w_outFire;
  logic              w_headLoad;
  logic              w_headBubble;
  logic              w_headBubblePc;
  logic [31:0]       w_headInstr;
  logic [31:0]       w_headPc8;
  logic [DATA_W-1:0] w_headData;

  assign w_inFire  = in_valid & w_inReady;
  assign w_outFire = r_outValid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_outValid <= (w_nextState != EMPTY);
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_inFire) w_nextState = ONE;
        ONE: begin
          if (w_outFire && !w_inFire) w_nextState = EMPTY;
`ifdef PIPE_SKID_EN
          else if (w_inFire && !w_outFire) w_nextState = TWO;
`endif
        end
        TWO:     if (w_outFire) w_nextState = ONE;
        default: w_nextState = EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_EN
  logic              r_inReady;
  logic              w_headFromSkid;
  logic              w_skidLoad;
  logic              w_skidBubble;
  logic [31:0]       w_skidInstr;
  logic [31:0]       w_skidPc8;
  logic [DATA_W-1:0] w_skidData;

  always_ff @(posedge clk) begin
    if (reset) r_inReady <= 1'b1;
    else       r_inReady <= (w_nextState != TWO);
  end
  assign w_inReady = r_inReady;
`else
  assign w_inReady = !r_outValid | out_ready;
`endif

  always_comb begin
    w_headLoad     = 1'b0;
    w_headBubble   = 1'b0;
    w_headBubblePc = 1'b0;
`ifdef PIPE_SKID_EN
    w_headFromSkid = 1'b0;
    w_skidLoad     = 1'b0;
    w_skidBubble   = 1'b0;
`endif
    if (flush) begin
      w_headBubble   = 1'b1;
      w_headBubblePc = 1'b1;
`ifdef PIPE_SKID_EN
      w_skidBubble   = 1'b1;
`endif
    end else begin
      case (r_state)
        EMPTY: w_headLoad = w_inFire;
        ONE: begin
          if (w_inFire && w_outFire) w_headLoad = 1'b1;
`ifdef PIPE_SKID_EN
          else if (w_inFire)         w_skidLoad = 1'b1;
`endif
          else if (w_outFire)        w_headBubble = 1'b1;
        end
        TWO: begin
`ifdef PIPE_SKID_EN
          if (w_outFire) begin
            w_headLoad     = 1'b1;
            w_headFromSkid = 1'b1;
            w_skidBubble   = 1'b1;
          end
`endif
        end
        default: w_headLoad = 1'b0;
      endcase
    end
  end

`ifdef PIPE_SKID_EN
  assign w_headInstr = w_headFromSkid ? w_skidInstr : in_instr;
  assign w_headPc8   = w_headFromSkid ? w_skidPc8   : in_pc8;
  assign w_headData  = w_headFromSkid ? w_skidData  : in_data;

  pipe_slot #(
    .DATA_W(DATA_W), .PC_RST(PC_RST), .BUBBLE_INSTR(BUBBLE_INSTR)
  ) uSkid (
    .clk(clk), .reset(reset), .load(w_skidLoad), .bubble(w_skidBubble),
    .bubblePc(1'b0), .dInstr(in_instr), .dPc8(in_pc8), .dData(in_data),
    .qInstr(w_skidInstr), .qPc8(w_skidPc8), .qData(w_skidData)
  );
`else
  assign w_headInstr = in_instr;
  assign w_headPc8   = in_pc8;
  assign w_headData  = in_data;
`endif

  pipe_slot #(
    .DATA_W(DATA_W), .PC_RST(PC_RST), .BUBBLE_INSTR(BUBBLE_INSTR)
  ) uHead (
    .clk(clk), .reset(reset), .load(w_headLoad), .bubble(w_headBubble),
    .bubblePc(w_headBubblePc), .dInstr(w_headInstr), .dPc8(w_headPc8),
    .dData(w_headData), .qInstr(out_instr), .qPc8(out_pc8), .qData(out_data)
  );

  assign in_ready  = w_inReady;
  assign out_valid = r_outValid;
  assign occupancy = pipe_occ_t'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// Scoreboard bench for pipe_stage_elastic: queue model of accepted entries,
// monitor compares every presented head and the idle bubble state.
module tb_pipe_stage_elastic;

  localparam int          DATA_W = 64;
  localparam logic [31:0] PC_RST = 32'h0000_3008;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc8;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_instr, in_pc8, out_instr, out_pc8;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;

  entry_t      expQ[$];
  logic [31:0] emptyPc;
  bit          modelInReady = 1'b0;
  bit          started = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc8(in_pc8), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc8(out_pc8), .out_data(out_data),
    .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: compare presented head against the scoreboard, pop on consume.
  always @(negedge clk) begin : mon
    int sz;
    if (started) begin
      sz = expQ.size();
      modelInReady = SKID ? (sz < 2) : (sz == 0 || out_ready);
      check("out_valid", 64'(out_valid), 64'(sz > 0));
      check("occupancy", 64'(occupancy), 64'(sz));
      check("in_ready", 64'(in_ready), 64'(modelInReady));
      if (sz > 0) begin
        check("head_instr", 64'(out_instr), 64'(expQ[0].instr));
        check("head_pc8", 64'(out_pc8), 64'(expQ[0].pc8));
        check("head_data", out_data, expQ[0].data);
        if (out_ready) begin
          emptyPc = expQ[0].pc8;
          void'(expQ.pop_front());
        end
      end else begin
        check("idle_instr", 64'(out_instr), 64'h0);
        check("idle_data", out_data, 64'h0);
        check("idle_pc8", 64'(out_pc8), 64'(emptyPc));
      end
    end
  end

  // One clock: drive inputs, then update the model at the edge.
  task automatic cyc(input bit rst, input bit fl, input bit iv, input logic [31:0] ins,
                     input logic [31:0] pc, input logic [DATA_W-1:0] d, input bit ordy,
                     output bit acc);
    reset = rst; flush = fl; in_valid = iv; in_instr = ins; in_pc8 = pc;
    in_data = d; out_ready = ordy;
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      expQ.delete();
      emptyPc = PC_RST;
    end else if (fl) begin
      expQ.delete();
      emptyPc = pc;
    end else if (iv && modelInReady) begin
      expQ.push_back({ins, pc, d});
      acc = 1'b1;
    end
    started = 1'b1;
    #1;
  endtask

  initial begin
    bit          acc;
    logic [31:0] pc;
    entry_t      pend[$];
    entry_t      e;

    // Reset dominates a same-cycle offer.
    cyc(1, 0, 1, 32'h2408_0005, 32'h0000_4000, 64'h1, 0, acc);
    cyc(1, 0, 1, 32'h2408_0005, 32'h0000_4000, 64'h1, 0, acc);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_pc8", 64'(out_pc8), 64'h3008);
    check("rst_instr", 64'(out_instr), 64'h0);
    check("rst_occ", 64'(occupancy), 64'h0);

    // Streaming, one cycle latency, no gaps.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 32'h1000_0000 + i, 32'h3008 + 4 * i, 64'hA0 + i, 1, acc);
      check("stream_valid", 64'(out_valid), 64'h1);
      check("stream_pc8", 64'(out_pc8), 64'(32'h3008 + 4 * i));
    end
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, acc);

    // Backpressure: three offers held by upstream until accepted.
    for (int i = 0; i < 3; i++) pend.push_back({32'h2000_0000 + i, 32'h3040 + 4 * i, 64'hB0 + i});
    for (int c = 0; c < 14; c++) begin
      if (c == 4) begin
        check("bp_occ", 64'(occupancy), SKID ? 64'h2 : 64'h1);
        check("bp_in_ready", 64'(in_ready), 64'h0);
      end
      if (pend.size() > 0) begin
        e = pend[0];
        cyc(0, 0, 1, e.instr, e.pc8, e.data, c >= 4, acc);
        if (acc) void'(pend.pop_front());
      end else begin
        cyc(0, 0, 0, 0, 0, 0, 1, acc);
      end
    end
    check("bp_all_sent", 64'(pend.size()), 64'h0);
    check("bp_all_drained", 64'(expQ.size()), 64'h0);

    // Flush while full with a same-cycle offer.
    cyc(0, 0, 1, 32'h3000_0001, 32'h3100, 64'hC1, 0, acc);
    cyc(0, 0, 1, 32'h3000_0002, 32'h3104, 64'hC2, 0, acc);
    cyc(0, 1, 1, 32'h3000_0003, 32'h3020, 64'hC3, 0, acc);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_instr", 64'(out_instr), 64'h0);
    check("flush_pc8", 64'(out_pc8), 64'h3020);
    check("flush_occ", 64'(occupancy), 64'h0);
    check("flush_in_ready", 64'(in_ready), 64'h1);

    // Flush with no offer still captures the PC.
    cyc(0, 1, 0, 32'hDEAD_BEEF, 32'h3100, 64'hC4, 0, acc);
    check("flush_idle_pc8", 64'(out_pc8), 64'h3100);
    check("flush_idle_valid", 64'(out_valid), 64'h0);

    // Reset beats flush and handshake together.
    cyc(0, 0, 1, 32'h3000_0005, 32'h3200, 64'hC5, 0, acc);
    cyc(1, 1, 1, 32'h3000_0006, 32'h3500, 64'hC6, 1, acc);
    check("rst_flush_pc8", 64'(out_pc8), 64'h3008);
    check("rst_flush_valid", 64'(out_valid), 64'h0);

    // Randomized traffic with occasional flush and reset.
    pc = 32'h3008;
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) < 6, $urandom(), pc, {$urandom(), $urandom()},
          $urandom_range(0, 9) < 6, acc);
      if (acc) pc = pc + 32'd4;
    end
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 1, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
